// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and sizes for the arithmetic unit and its result buffer.
package alu_pkg;
    localparam int ALU_DATA_WIDTH   = 16;
    localparam int RESULT_BUF_DEPTH = 4;
    localparam int DROP_CNT_WIDTH   = 8;
    localparam int ALU_ENTRY_WIDTH  = ALU_DATA_WIDTH + 1;
endpackage

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: register-array FIFO with wrapping pointers and a separate occupancy counter.
module alu_sync_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_ENTRY_WIDTH,
    parameter int DEPTH = RESULT_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= (push && !pop) ? level + 1'b1 :
                     (pop && !push) ? level - 1'b1 : level;
        end
    end

    // Storage is deliberately left out of reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_comb begin
        rdata = mem[rd_ptr];
        full  = level == FULL_LEVEL;
        empty = level == '0;
    end
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: queues valid ALU results for a stallable consumer and counts overflow drops.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int OUT_DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int DEPTH          = RESULT_BUF_DEPTH,
    parameter int CNT_WIDTH      = DROP_CNT_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [OUT_DATA_WIDTH-1:0]  In_Data,
    input  logic                       In_Carry,
    input  logic                       In_Flag,
    output logic [OUT_DATA_WIDTH-1:0]  Out_Data,
    output logic                       Out_Carry,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic                       Full,
    output logic                       Empty,
    output logic [$clog2(DEPTH):0]     Level,
    output logic [CNT_WIDTH-1:0]       Drop_Count
);
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [OUT_DATA_WIDTH:0] head;

    alu_sync_fifo #(.WIDTH(OUT_DATA_WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .wdata ({In_Carry, In_Data}),
        .rdata (head),
        .full  (Full),
        .empty (Empty),
        .level (Level)
    );

    // A pop frees a slot in the same cycle, so a full buffer still accepts.
    always_comb begin
        Out_Valid             = !Empty;
        pop                   = Out_Valid && Out_Ready;
        push                  = In_Flag && (!Full || pop);
        drop                  = In_Flag && Full && !pop;
        {Out_Carry, Out_Data} = Empty ? '0 : head;
    end

    always_ff @(posedge CLK) begin
        if (RST) Drop_Count <= '0;
        else if (drop && Drop_Count != '1) Drop_Count <= Drop_Count + 1'b1;
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: random and directed stimulus checked against a queue-based reference model.
module tb_alu_result_buffer;
    import alu_pkg::*;
    localparam int W = ALU_DATA_WIDTH;
    localparam int D = RESULT_BUF_DEPTH;
    localparam int C = DROP_CNT_WIDTH;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [W-1:0]         In_Data = '0;
    logic                 In_Carry = 1'b0;
    logic                 In_Flag = 1'b0;
    logic                 Out_Ready = 1'b0;
    logic [W-1:0]         Out_Data;
    logic                 Out_Carry;
    logic                 Out_Valid;
    logic                 Full;
    logic                 Empty;
    logic [$clog2(D):0]   Level;
    logic [C-1:0]         Drop_Count;

    logic [W:0] q[$];
    int drops = 0;
    int vectors = 0;
    int errors = 0;

    alu_result_buffer dut (
        .CLK        (CLK),
        .RST        (RST),
        .In_Data    (In_Data),
        .In_Carry   (In_Carry),
        .In_Flag    (In_Flag),
        .Out_Data   (Out_Data),
        .Out_Carry  (Out_Carry),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Full       (Full),
        .Empty      (Empty),
        .Level      (Level),
        .Drop_Count (Drop_Count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [W:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        check("valid", 32'(Out_Valid), 32'(q.size() != 0));
        check("data",  32'(Out_Data),  32'(head[W-1:0]));
        check("carry", 32'(Out_Carry), 32'(head[W]));
        check("empty", 32'(Empty),     32'(q.size() == 0));
        check("full",  32'(Full),      32'(q.size() == D));
        check("level", 32'(Level),     32'(q.size()));
        check("drops", 32'(Drop_Count), 32'(drops));
    endtask

    task automatic step(input logic rst, input logic flag, input logic carry,
                        input logic ready, input logic [W-1:0] data);
        logic do_pop;
        logic do_push;
        @(negedge CLK);
        RST = rst; In_Flag = flag; In_Carry = carry; In_Data = data; Out_Ready = ready;
        @(posedge CLK);
        if (rst) begin
            q.delete();
            drops = 0;
        end else begin
            do_pop  = (q.size() != 0) && ready;
            do_push = flag && ((q.size() < D) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({carry, data});
            else if (flag && drops < (1 << C) - 1) drops++;
        end
        #1 compare_all();
    endtask

    initial begin
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_level", 32'(Level), 32'd0);

        step(0, 1, 1, 0, 16'h00FF);
        check("single_data",  32'(Out_Data),  32'h00FF);
        check("single_carry", 32'(Out_Carry), 32'd1);
        check("single_level", 32'(Level),     32'd1);
        step(0, 0, 0, 1, '0);
        check("single_drain", 32'(Out_Data), 32'd0);

        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 0, W'(i));
            if (i == 4) check("fill_full", 32'(Full), 32'd1);
        end
        check("ovf_drops", 32'(Drop_Count), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order", 32'(Out_Data), 32'(i));
            step(0, 0, 0, 1, '0);
        end

        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, W'(16'h10 + i));
        step(0, 1, 0, 1, 16'h14);
        check("pp_level", 32'(Level), 32'd4);
        check("pp_drops", 32'(Drop_Count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("pp_order", 32'(Out_Data), 32'(16'h11 + i));
            step(0, 0, 0, 1, '0);
        end

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 1, W'(16'h100 + i));
            check("stream_data", 32'(Out_Data), 32'(16'h100 + i));
            check("stream_lvl",  32'(Level <= 1), 32'd1);
        end
        step(0, 0, 0, 1, '0);

        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, W'(16'h200 + i));
        for (int i = 0; i < 300; i++) step(0, 1, 0, 0, W'($urandom));
        check("sat_drops", 32'(Drop_Count), 32'hFF);
        step(0, 0, 0, 1, '0);
        check("pre_rst_level", 32'(Level), 32'd3);
        step(1, 1, 1, 0, 16'hBEEF);
        check("midrst_empty", 32'(Empty), 32'd1);
        check("midrst_drops", 32'(Drop_Count), 32'd0);
        step(0, 0, 0, 0, '0);
        check("rst_flag_ignored", 32'(Empty), 32'd1);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 1'($urandom), W'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the arithmetic unit. Captures each registered result (data plus carry) that the arithmetic unit flags as valid and queues it in a small FIFO. It presents queued results to the consumer over a valid/ready handshake and counts results lost to overflow. It decouples the one-result-per-cycle arithmetic pipeline from a consumer that may stall.

## Interface
- OUT_DATA_WIDTH, 16, width of a result word; matches the arithmetic unit's result width
- DEPTH, 4, number of FIFO entries; power of two, ≥2
- CNT_WIDTH, 8, width of the drop counter
- CLK  in  1  sole clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- In_Data  in  OUT_DATA_WIDTH  result word from arithmetic unit
- In_Carry  in  1  carry bit accompanying In_Data
- In_Flag  in  1  result-valid strobe; one result per cycle while high
- Out_Data  out  OUT_DATA_WIDTH  head-of-queue result word
- Out_Carry  out  1  head-of-queue carry
- Out_Valid  out  1  head entry present
- Out_Ready  in  1  consumer accepts head this cycle
- Full  out  1  DEPTH entries held
- Empty  out  1  zero entries held
- Level  out  $clog2(DEPTH)+1  current occupancy
- Drop_Count  out  CNT_WIDTH  results discarded because of overflow; saturating

## Operation
- Entry = {carry, data}, OUT_DATA_WIDTH+1 bits. Storage is a register array, indexed by write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Occupancy is held in a separate Level counter.
- Push condition: In_Flag && (!Full || pop).
- Pop condition: Out_Valid && Out_Ready.
- Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
- Level update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Full when Level==DEPTH. Empty when Level==0. Out_Valid = !Empty.
- Out_Data/Out_Carry = mem[rd_ptr] when !Empty; forced to 0 when Empty. No X ever reaches the output.
- Overflow: In_Flag while Full and no pop in the same cycle drops the input. Storage and pointers are unchanged. Drop_Count increments by 1 and saturates at 2^CNT_WIDTH−1.
- Full with simultaneous pop and In_Flag: the push is accepted, nothing is dropped, and Level stays DEPTH.
- Empty with In_Flag: the push is accepted. No pop is possible because Out_Valid is low.
- Out_Ready while Empty has no effect.
- Reset values: pointers 0, Level 0, Empty 1, Full 0, Out_Valid 0, Out_Data 0, Out_Carry 0, Drop_Count 0. Memory contents are not reset.
- Reset mid-operation discards all queued entries and clears Drop_Count. In_Flag in the reset cycle is ignored.

## Timing
- Write latency: a result sampled with In_Flag at edge N appears at Out_Data with Out_Valid high after edge N if the FIFO was empty (one cycle, registered). Otherwise it appears after all older entries pop.
- Pop: the head is consumed at the edge where Out_Valid && Out_Ready. The next entry is visible right after that edge. Sustained throughput is 1 entry/cycle in both directions.
- Full, Empty, Level and Drop_Count are registered-state derived and update at the same edge as the push/pop that changes them.
- No combinational path from In_Flag or In_Data to any output. Out_Valid does not depend on Out_Ready.

## Structure
- Shared package alu_pkg holds:
  - ALU_DATA_WIDTH (16)
  - RESULT_BUF_DEPTH (4)
  - DROP_CNT_WIDTH (8)
  - the entry-width constant (ALU_DATA_WIDTH+1), used by this block and the arithmetic unit integration
- One natural sub-module: alu_sync_fifo. It contains the parameterised storage, pointers and Level logic with push/pop/Full/Empty.
- alu_result_buffer wraps alu_sync_fifo and adds:
  - push gating
  - output zero-forcing
  - the saturating drop counter

## Test plan
- Reset then idle: RST high 2 cycles. Expect all outputs at reset values, Empty=1, Level=0, Drop_Count=0.
- Single pass: push {carry=1, 0x00FF} with Out_Ready=0. Next cycle Out_Valid=1, Out_Data=0x00FF, Out_Carry=1, Level=1. Raise Out_Ready for one cycle: Empty=1, Out_Data=0.
- Fill and overflow: push 0x0001..0x0006 on consecutive cycles with Out_Ready=0. Expect Full after the 4th push, Drop_Count=2, and drain order 0x0001, 0x0002, 0x0003, 0x0004.
- Full with simultaneous push/pop: fill with 0x0010..0x0013, then push 0x0014 with Out_Ready=1. Expect no drop, Level stays 4, and drain order 0x0011, 0x0012, 0x0013, 0x0014.
- Streaming wrap-around: In_Flag and Out_Ready both high for 20 cycles with incrementing data from 0x0100. Expect outputs 0x0100.. in order one cycle behind the inputs, Level ≤1, pointers wrapping without loss.
- Saturation and reset mid-operation:
  - force 300 overflow pushes: Drop_Count=0x00FF
  - assert RST with 3 entries queued: Empty=1 and Drop_Count=0 the cycle after
  - In_Flag during the reset cycle is not stored
